// File: rtl/vend_pkg.sv
// vend_pkg: shared state, coin values and greedy change selection for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  localparam int NICKEL_V = 1;
  localparam int DIME_V = 2;
  localparam int QUARTER_V = 5;
  typedef logic [2:0] coin_oh_t;
  function automatic coin_oh_t change_sel(input int r);
    return r >= QUARTER_V ? 3'b100 : r >= DIME_V ? 3'b010 : r >= NICKEL_V ? 3'b001 : 3'b000;
  endfunction
  function automatic int coin_val(input coin_oh_t c);
    return c[2] ? QUARTER_V : c[1] ? DIME_V : c[0] ? NICKEL_V : 0;
  endfunction
endpackage

// File: rtl/vend_change_unit.sv
// vend_change_unit: holds remaining change and pays it out greedily, one coin per cycle
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output coin_oh_t     coin,
  output logic [W-1:0] rem,
  output logic         done
);
  logic [W-1:0] src;
  coin_oh_t pick;
  always_comb begin
    src = load ? load_val : rem;
    pick = change_sel(int'(src));
    done = rem == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      coin <= '0;
      rem <= '0;
    end else begin
      coin <= pick;
      rem <= src - W'(coin_val(pick));
    end
  end
endmodule

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: multi-product vending controller; define VEND_TIMEOUT_EN to auto-refund credit after TIMEOUT_CYC idle cycles
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int N_PROD = 4,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 40,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd7, 8'd5, 8'd4, 8'd3},
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      nickel,
  input  logic                      dime,
  input  logic                      quarter,
  input  logic                      sel_valid,
  input  logic [$clog2(N_PROD)-1:0] sel,
  input  logic                      cancel,
  output logic                      vend,
  output logic [$clog2(N_PROD)-1:0] vend_id,
  output logic                      chg_nickel,
  output logic                      chg_dime,
  output logic                      chg_quarter,
  output logic                      coin_reject,
  output logic                      sel_denied,
  output logic [CREDIT_W-1:0]       credit,
  output logic                      busy
);
  state_t state, state_nx;
  logic [CREDIT_W-1:0] credit_q, rem, coin_v, price;
  coin_oh_t coin;
  logic done, open_st, any_coin, coin_ok, sel_ok, can_cancel, load, tmo;
`ifdef VEND_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYC+1)-1:0] tmr;
  always_comb tmo = state == CREDIT && int'(tmr) == TIMEOUT_CYC - 1 && !any_coin && !sel_valid;
  always_ff @(posedge clk) begin
    if (rst || state != CREDIT || coin_ok || sel_ok) tmr <= '0;
    else if (int'(tmr) < TIMEOUT_CYC - 1) tmr <= tmr + 1'b1;
  end
`else
  always_comb tmo = 1'b0;
`endif
  vend_change_unit #(.W(CREDIT_W)) u_chg (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(credit_q),
    .coin(coin),
    .rem(rem),
    .done(done)
  );
  always_comb begin
    open_st = state == IDLE || state == CREDIT;
    any_coin = nickel | dime | quarter;
    coin_v = CREDIT_W'(quarter ? QUARTER_V : dime ? DIME_V : NICKEL_V);
    price = int'(sel) < N_PROD ? PRICES[int'(sel)*CREDIT_W +: CREDIT_W] : '0;
    can_cancel = state == CREDIT && (cancel || tmo);
    coin_ok = open_st && !can_cancel && $onehot({nickel, dime, quarter})
              && int'(credit_q) + int'(coin_v) <= MAX_CREDIT;
    sel_ok = open_st && !can_cancel && !any_coin && sel_valid && int'(sel) < N_PROD && credit_q >= price;
    load = can_cancel || (state == VEND && credit_q != '0);
    credit = state == CHANGE ? rem : credit_q;
  end
  always_comb begin
    state_nx = can_cancel ? CHANGE : sel_ok ? VEND : coin_ok ? CREDIT :
               state == VEND ? (credit_q != '0 ? CHANGE : IDLE) :
               state == CHANGE ? (done ? IDLE : CHANGE) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
      vend <= 1'b0;
      vend_id <= '0;
      coin_reject <= 1'b0;
      sel_denied <= 1'b0;
      busy <= 1'b0;
    end else begin
      credit_q <= load ? '0 : sel_ok ? credit_q - price : coin_ok ? credit_q + coin_v : credit_q;
      vend <= sel_ok;
      vend_id <= sel_ok ? sel : '0;
      coin_reject <= any_coin && !coin_ok;
      sel_denied <= sel_valid && !sel_ok;
      busy <= state_nx == VEND || state_nx == CHANGE;
    end
  end
  always_comb {chg_quarter, chg_dime, chg_nickel} = coin;
endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised vending controller that succeeds the single-product soda machine. It takes nickel/dime/quarter coin pulses and accumulates credit in nickel units. It supports N_PROD products with per-product prices, a cancel/refund request, and multi-cycle change dispensing at one coin per clock. It sits between the coin acceptor front end and the product/coin dispenser actuators.

Parameters:
N_PROD, 4, number of selectable products (>=2)
CREDIT_W, 8, credit register width in nickel units
MAX_CREDIT, 40, credit ceiling in nickels (40 = $2.00); must fit CREDIT_W
PRICES, {8'd7,8'd5,8'd4,8'd3}, packed N_PROD*CREDIT_W price table in nickels; slice i = product i
TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with VEND_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
nickel  in  1  coin pulse, value 1
dime  in  1  coin pulse, value 2
quarter  in  1  coin pulse, value 5
sel_valid  in  1  product selection strobe
sel  in  $clog2(N_PROD)  selected product index
cancel  in  1  refund request
vend  out  1  one-cycle product release pulse
vend_id  out  $clog2(N_PROD)  product index, valid with vend
chg_nickel / chg_dime / chg_quarter  out  1 each  one-cycle coin-return pulses, at most one high per cycle
coin_reject  out  1  one-cycle pulse: coin returned uncredited
sel_denied  out  1  one-cycle pulse: selection refused
credit  out  CREDIT_W  current credit in nickels
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset: all outputs are 0, credit is 0, state is IDLE. Reset overrides everything, including mid-vend and mid-change.
- All outputs are registered. Responses appear the cycle after the input is sampled.
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0, accepting coins and selections.
  - VEND: single cycle.
  - CHANGE: dispensing change.
- Coin handling in IDLE/CREDIT:
  - Exactly one coin line high and credit + value <= MAX_CREDIT: credit += value; IDLE -> CREDIT.
  - More than one coin line high, or credit would overflow: coin_reject = 1, credit unchanged.
  - Any coin in VEND/CHANGE: coin_reject.
- Priority within a cycle: cancel > coin > sel_valid.
  - Coin and sel_valid together: the coin is processed and the selection is dropped with sel_denied.
  - cancel plus coin: the coin is rejected and the refund starts.
- Selection in IDLE/CREDIT:
  - sel >= N_PROD or credit < PRICES[sel]: sel_denied = 1, state unchanged.
  - Otherwise -> VEND: vend = 1, vend_id = sel, credit -= price.
- VEND exit: remainder > 0 -> CHANGE; else -> IDLE.
- cancel:
  - In CREDIT: -> CHANGE with the full credit.
  - In IDLE: ignored.
  - In VEND/CHANGE: ignored.
- CHANGE dispenses greedily, one coin per cycle:
  - credit >= 5: quarter, credit -= 5.
  - else credit >= 2: dime, credit -= 2.
  - else: nickel, credit -= 1.
  - Leaves to IDLE in the cycle credit reaches 0.
  - Change for remainder R takes exactly floor(R/5) + floor((R mod 5)/2) + (R mod 5 mod 2) cycles.
- sel_valid during VEND/CHANGE: sel_denied.
- Credit never exceeds MAX_CREDIT and never underflows.

Optional Feature:
Macro VEND_TIMEOUT_EN.
- Defined: a counter resets on every accepted coin or selection while in CREDIT. Reaching TIMEOUT_CYC idle cycles forces CREDIT -> CHANGE, a full refund identical to cancel.
- Undefined: there is no counter, and credit is held indefinitely.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, CREDIT, VEND, CHANGE);
  - coin value constants NICKEL_V = 1, DIME_V = 2, QUARTER_V = 5;
  - coin-return one-hot typedef;
  - greedy change-select function.
- Sub-module vend_change_unit is natural. It holds remaining change and emits one coin per cycle plus a done flag, and is loaded from the main FSM.

Test Plan:
1. Reset, then dime, dime, sel=1 (price 4) -> vend = 1 with vend_id = 1 one cycle after sel; no change pulses; credit 0; IDLE.
2. quarter, then sel=0 (price 3) -> vend, then chg_dime one cycle; busy for 2 cycles total; credit 0.
3. nickel, sel=2 (price 5) -> sel_denied pulse, credit stays 1; then cancel -> single chg_nickel, IDLE.
4. 8 quarters (credit 40), then nickel -> coin_reject, credit stays 40; cancel -> 8 consecutive chg_quarter pulses, then IDLE.
5. nickel and dime high in the same cycle -> coin_reject, credit 0; dime plus sel_valid together -> credit 2, sel_denied.
6. rst asserted on the 3rd cycle of an 8-quarter refund -> next cycle all outputs 0, credit 0, IDLE, no further chg_* pulses. With VEND_TIMEOUT_EN and TIMEOUT_CYC = 20: dime, then 20 idle cycles -> chg_dime, IDLE.
